asrv32_pipeline_ctrl: RTL and testbench

Central hazard and control-flow sequencer for the ASRV32 5-stage pipeline. It drives the stall and flush inputs of IF/ID/EX from three inputs: load-use hazards at the ID stage, branch/jump resolution in EX, and trap entry/return (exceptions, MRET). A small FSM drains the memory stage before any trap redirect. It then issues a single redirect to the fetch unit.

---
 rtl/asrv32_pipeline_ctrl.sv | 163 ++++++++++++++++
 tb/tb_asrv32_pipeline_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asrv32_pipeline_ctrl.sv
// asrv32_pipeline_ctrl
// Hazard and control-flow sequencer for the ASRV32 5-stage pipeline.
// Load-use hazards stall IF/ID for one cycle. Taken branches redirect fetch
// in the same cycle. Traps and MRET go through DRAIN, which waits for the
// memory stage to go idle or for a bounded timeout. A single REDIRECT cycle
// then issues the trap or return redirect.
module asrv32_pipeline_ctrl #(
   parameter int DRAIN_TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_id_valid,
   input  logic [4:0]  i_rs1_addr,
   input  logic [4:0]  i_rs2_addr,
   input  logic        i_ex_valid,
   input  logic        i_ex_load,
   input  logic [4:0]  i_ex_rd_addr,
   input  logic        i_mem_busy,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_exception,
   input  logic        i_mret,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_trap_vector,
   input  logic [31:0] i_mepc,
   output logic        o_stall,
   output logic        o_flush,
   output logic        o_flush_ex,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc,
   output logic        o_mepc_wr,
   output logic [31:0] o_mepc_val,
   output logic        o_trap_enter,
   output logic        o_trap_return,
   output logic        o_drain_timeout
);

   // The counter is at least 4 bits wide and can always hold DRAIN_TIMEOUT.
   localparam int CNT_W = ($clog2(DRAIN_TIMEOUT + 1) > 4) ? $clog2(DRAIN_TIMEOUT + 1) : 4;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(DRAIN_TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_kind;          // 1 = MRET, 0 = trap
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_mepc_val;
   logic             r_mepc_wr;
   logic             r_trap_enter;
   logic             r_trap_return;
   logic             r_drain_timeout;

   logic             w_load_use;
   logic             w_run_ok;
   logic             w_trap_evt;
   logic             w_branch_evt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_timeout_hit;
   logic             w_drain_exit;

   assign w_load_use = i_id_valid & i_ex_valid & i_ex_load & (i_ex_rd_addr != 5'd0) &
                       ((i_ex_rd_addr == i_rs1_addr) | (i_ex_rd_addr == i_rs2_addr));

   // EX events are acted on only in RUN, and only when MEM is not holding EX stalled.
   assign w_run_ok     = (r_state == ST_RUN) & i_ex_valid & ~i_mem_busy;
   assign w_trap_evt   = w_run_ok & (i_exception | i_mret);
   assign w_branch_evt = w_run_ok & i_branch_taken & ~(i_exception | i_mret);

   // The counter saturates. DRAIN exits on the busy cycle in which the counter reaches the limit.
   assign w_cnt_next    = (r_cnt == TIMEOUT_VAL) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_timeout_hit = i_mem_busy & (w_cnt_next == TIMEOUT_VAL);
   assign w_drain_exit  = ~i_mem_busy | w_timeout_hit;

   assign o_stall = w_load_use | i_mem_busy | (r_state == ST_DRAIN);

   // Combinational flush and redirect outputs, decoded from the state and the current EX events.
   always_comb begin
      // NOTE: each output is given a default first, so no path through the case infers a latch.
      o_flush       = 1'b0;
      o_flush_ex    = 1'b0;
      o_redirect    = 1'b0;
      o_redirect_pc = 32'd0;
      case (r_state)
         ST_RUN: begin
            o_flush    = w_trap_evt | w_branch_evt;
            o_flush_ex = w_trap_evt;
            o_redirect = w_branch_evt;
            if (w_branch_evt) begin
               o_redirect_pc = i_branch_target;
            end
         end
         ST_DRAIN: begin
            o_flush = 1'b1;
         end
         ST_REDIRECT: begin
            o_flush       = 1'b1;
            o_redirect    = 1'b1;
            o_redirect_pc = r_kind ? i_mepc : i_trap_vector;
         end
         default: begin
         end
      endcase
   end

   // Trap FSM. The pulse outputs are registered on entry to REDIRECT, so they are high exactly in that cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= ST_RUN;
         r_kind          <= 1'b0;
         r_cnt           <= '0;
         r_mepc_val      <= 32'd0;
         r_mepc_wr       <= 1'b0;
         r_trap_enter    <= 1'b0;
         r_trap_return   <= 1'b0;
         r_drain_timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples values from before the edge.
         r_mepc_wr       <= 1'b0;
         r_trap_enter    <= 1'b0;
         r_trap_return   <= 1'b0;
         r_drain_timeout <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (w_trap_evt) begin
                  r_kind     <= i_mret;
                  r_mepc_val <= i_ex_pc;
                  r_cnt      <= '0;
                  r_state    <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (i_mem_busy) begin
                  r_cnt <= w_cnt_next;
               end
               if (w_drain_exit) begin
                  r_state         <= ST_REDIRECT;
                  r_trap_enter    <= ~r_kind;
                  r_trap_return   <= r_kind;
                  r_mepc_wr       <= ~r_kind;
                  r_drain_timeout <= w_timeout_hit;
               end
            end
            ST_REDIRECT: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign o_mepc_val      = r_mepc_val;
   assign o_mepc_wr       = r_mepc_wr;
   assign o_trap_enter    = r_trap_enter;
   assign o_trap_return   = r_trap_return;
   assign o_drain_timeout = r_drain_timeout;

endmodule

// File: tb/tb_asrv32_pipeline_ctrl.sv
// Testbench for asrv32_pipeline_ctrl.
// Applies directed stimulus with hand-computed expectations. A behavioural
// model, expressed as a pending trap plus a count of busy cycles, is checked
// against every output on each falling clock edge.
module tb_asrv32_pipeline_ctrl;

   localparam int TIMEOUT = 15;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        ex_valid;
   logic        ex_load;
   logic [4:0]  ex_rd_addr;
   logic        mem_busy;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        exception;
   logic        mret;
   logic [31:0] ex_pc;
   logic [31:0] trap_vector;
   logic [31:0] mepc;
   logic        stall;
   logic        flush;
   logic        flush_ex;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mepc_wr;
   logic [31:0] mepc_val;
   logic        trap_enter;
   logic        trap_return;
   logic        drain_timeout;

   int n_cmp = 0;
   int n_bad = 0;

   asrv32_pipeline_ctrl #(.DRAIN_TIMEOUT(TIMEOUT)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_id_valid      (id_valid),
      .i_rs1_addr      (rs1_addr),
      .i_rs2_addr      (rs2_addr),
      .i_ex_valid      (ex_valid),
      .i_ex_load       (ex_load),
      .i_ex_rd_addr    (ex_rd_addr),
      .i_mem_busy      (mem_busy),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_exception     (exception),
      .i_mret          (mret),
      .i_ex_pc         (ex_pc),
      .i_trap_vector   (trap_vector),
      .i_mepc          (mepc),
      .o_stall         (stall),
      .o_flush         (flush),
      .o_flush_ex      (flush_ex),
      .o_redirect      (redirect),
      .o_redirect_pc   (redirect_pc),
      .o_mepc_wr       (mepc_wr),
      .o_mepc_val      (mepc_val),
      .o_trap_enter    (trap_enter),
      .o_trap_return   (trap_return),
      .o_drain_timeout (drain_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   bit          m_pend;          // a trap/MRET has been accepted and is draining
   bit          m_kind;          // 1 = MRET
   int          m_busy_cycles;   // busy cycles spent waiting while pending
   bit          m_redir;         // this cycle is the redirect cycle
   bit          m_to;            // the redirect was forced by timeout
   logic [31:0] m_mepc_val;

   initial begin
      bit          lu, in_run, run_ok, trap, br;
      logic [31:0] exp_pc;
      m_pend = 0; m_kind = 0; m_busy_cycles = 0; m_redir = 0; m_to = 0; m_mepc_val = 32'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_pend = 0; m_kind = 0; m_busy_cycles = 0; m_redir = 0; m_to = 0; m_mepc_val = 32'd0;
         end
         lu     = id_valid && ex_valid && ex_load && ex_rd_addr != 0 &&
                  (ex_rd_addr == rs1_addr || ex_rd_addr == rs2_addr);
         in_run = !m_pend && !m_redir;
         run_ok = in_run && ex_valid && !mem_busy;
         trap   = run_ok && (exception || mret);
         br     = run_ok && branch_taken && !trap;
         exp_pc = br ? branch_target : (m_redir ? (m_kind ? mepc : trap_vector) : 32'd0);

         check("m_stall",       {31'd0, stall},         {31'd0, lu || mem_busy || m_pend});
         check("m_flush",       {31'd0, flush},         {31'd0, trap || br || m_pend || m_redir});
         check("m_flush_ex",    {31'd0, flush_ex},      {31'd0, trap});
         check("m_redirect",    {31'd0, redirect},      {31'd0, br || m_redir});
         check("m_redirect_pc", redirect_pc,            exp_pc);
         check("m_trap_enter",  {31'd0, trap_enter},    {31'd0, m_redir && !m_kind});
         check("m_trap_return", {31'd0, trap_return},   {31'd0, m_redir && m_kind});
         check("m_mepc_wr",     {31'd0, mepc_wr},       {31'd0, m_redir && !m_kind});
         check("m_timeout",     {31'd0, drain_timeout}, {31'd0, m_redir && m_to});
         check("m_mepc_val",    mepc_val,               m_mepc_val);

         // advance the model to the state after the coming rising edge
         if (rst_n) begin
            if (m_redir) begin
               m_redir = 0;
               m_to    = 0;
            end else if (m_pend) begin
               if (!mem_busy) begin
                  m_pend = 0; m_redir = 1; m_to = 0;
               end else begin
                  m_busy_cycles++;
                  if (m_busy_cycles == TIMEOUT) begin
                     m_pend = 0; m_redir = 1; m_to = 1;
                  end
               end
            end else if (trap) begin
               m_pend = 1; m_kind = mret; m_mepc_val = ex_pc; m_busy_cycles = 0;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      id_valid = 0; rs1_addr = 0; rs2_addr = 0; ex_valid = 0; ex_load = 0; ex_rd_addr = 0;
      mem_busy = 0; branch_taken = 0; branch_target = 0; exception = 0; mret = 0; ex_pc = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int n;
      rst_n = 0;
      idle();
      trap_vector = 32'h0000_0200;
      mepc        = 32'h0000_0044;
      tick(); tick();
      settle();
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_mepc_val", mepc_val, 32'd0);
      check("rst_pulses", {28'd0, trap_enter, trap_return, mepc_wr, drain_timeout}, 32'd0);
      rst_n = 1;
      tick();

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      ex_valid = 1; ex_load = 1; ex_rd_addr = 5'd5; id_valid = 1; rs1_addr = 5'd5; rs2_addr = 5'd1;
      settle();
      check("lu_stall", {31'd0, stall}, 32'd1);
      tick();
      ex_load = 0;                       // the bubble has been inserted
      settle();
      check("lu_stall_once", {31'd0, stall}, 32'd0);
      tick();
      ex_load = 1; ex_rd_addr = 5'd1; rs1_addr = 5'd7; rs2_addr = 5'd1;
      settle();
      check("lu_rs2_stall", {31'd0, stall}, 32'd1);
      tick();
      ex_rd_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
      settle();
      check("lu_x0_stall", {31'd0, stall}, 32'd0);
      tick();
      idle();

      // taken branch
      ex_valid = 1; branch_taken = 1; branch_target = 32'h0000_0100;
      settle();
      check("br_redirect", {31'd0, redirect}, 32'd1);
      check("br_pc", redirect_pc, 32'h0000_0100);
      check("br_flush", {31'd0, flush}, 32'd1);
      check("br_flush_ex", {31'd0, flush_ex}, 32'd0);
      tick();
      idle();
      settle();
      check("br_still_run", {30'd0, stall, redirect}, 32'd0);
      tick();

      // ECALL at 0x40, memory idle
      ex_valid = 1; exception = 1; ex_pc = 32'h0000_0040;
      settle();
      check("ecall_flush_ex", {31'd0, flush_ex}, 32'd1);
      check("ecall_no_redir", {31'd0, redirect}, 32'd0);
      tick();
      idle();
      settle();
      check("ecall_drain", {30'd0, stall, flush}, 32'd3);
      tick();
      check("ecall_pc", redirect_pc, 32'h0000_0200);
      check("ecall_pulses", {29'd0, trap_enter, trap_return, mepc_wr}, 32'b101);
      check("ecall_mepc_val", mepc_val, 32'h0000_0040);
      tick();
      check("ecall_done", {30'd0, redirect, trap_enter}, 32'd0);

      // MRET, memory busy for the first 3 DRAIN cycles
      ex_valid = 1; mret = 1; ex_pc = 32'h0000_0080;
      settle();
      check("mret_flush_ex", {31'd0, flush_ex}, 32'd1);
      tick();
      idle(); mem_busy = 1;
      tick(); tick();
      tick();
      mem_busy = 0;
      settle();
      check("mret_wait", {30'd0, stall, redirect}, 32'b10);
      tick();
      check("mret_pc", redirect_pc, 32'h0000_0044);
      check("mret_pulses", {28'd0, trap_enter, trap_return, mepc_wr, drain_timeout}, 32'b0100);
      check("mret_mepc_val", mepc_val, 32'h0000_0080);
      tick();

      // exception deferred while MEM is busy
      ex_valid = 1; exception = 1; ex_pc = 32'h0000_00c0; mem_busy = 1;
      settle();
      check("defer_flush_ex", {31'd0, flush_ex}, 32'd0);
      tick();
      mem_busy = 0;
      settle();
      check("defer_taken", {31'd0, flush_ex}, 32'd1);
      tick();
      idle();
      tick();
      check("defer_enter", {31'd0, trap_enter}, 32'd1);
      tick();

      // DRAIN timeout: busy held for the whole drain
      ex_valid = 1; exception = 1; ex_pc = 32'h0000_0100;
      tick();
      idle(); mem_busy = 1;
      settle();
      n = 0;
      while (!drain_timeout && n < 40) begin
         n++;
         tick();
      end
      check("to_drain_cycles", n, 32'd15);
      check("to_redirect", {30'd0, redirect, trap_enter}, 32'b11);
      check("to_pc", redirect_pc, 32'h0000_0200);
      mem_busy = 0;
      tick();
      check("to_pulse_once", {31'd0, drain_timeout}, 32'd0);

      // exception and branch together: the exception wins
      ex_valid = 1; exception = 1; branch_taken = 1; branch_target = 32'h0000_0300; ex_pc = 32'h0000_0140;
      settle();
      check("exbr_no_redirect", {31'd0, redirect}, 32'd0);
      check("exbr_pc", redirect_pc, 32'd0);
      check("exbr_flush_ex", {31'd0, flush_ex}, 32'd1);
      tick();
      idle();
      tick();
      check("exbr_trap_pc", redirect_pc, 32'h0000_0200);
      tick();

      // reset asserted in the middle of DRAIN
      ex_valid = 1; exception = 1; ex_pc = 32'h0000_0180;
      tick();
      idle(); mem_busy = 1;
      tick();
      rst_n = 0; mem_busy = 0;
      settle();
      check("rstd_outputs", {29'd0, stall, flush, redirect}, 32'd0);
      check("rstd_mepc_val", mepc_val, 32'd0);
      tick();
      rst_n = 1;
      tick();
      check("rstd_no_pulse", {28'd0, trap_enter, trap_return, mepc_wr, redirect}, 32'd0);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
